exp_sequencer: RTL and testbench
================================

EXP_SEQUENCER -- requirements
Module: exp_sequencer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 6, giving the width of the bit-count and index signals.
REQ-002 The module SHALL have parameter DW, default 16, giving the width of the message, modulus, exponent and result.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin an exponentiation; honoured only in IDLE.
REQ-006 msg  input  DW  base operand; the caller guarantees msg < modulus.
REQ-007 exponent  input  DW  exponent (key) bits, processed LSB first.
REQ-008 modulus  input  DW  modulus; passed through unchanged on mul_n.
REQ-009 nbits  input  WIDTH  number of exponent bits to process; values above DW are clamped to DW.
REQ-010 mul_req  output  1  multiply request to the external modular multiplier.
REQ-011 mul_a, mul_b, mul_n  output  DW each  multiply operands and modulus.
REQ-012 mul_ack  input  1  multiplier acknowledge; mul_p is valid in the same cycle.
REQ-013 mul_p  input  DW  product (mul_a*mul_b mod mul_n).
REQ-014 count  output  WIDTH  index of the exponent bit currently being processed.
REQ-015 busy  output  1  high from the cycle after an accepted start until done.
REQ-016 done  output  1  one-cycle pulse when result is valid.
REQ-017 result  output  DW  msg^exponent mod modulus; held from done until the next accepted start.

Function
REQ-018 States SHALL be IDLE, CHECK, MUL, SQR and FIN.
REQ-019 IDLE + start: latch msg, exponent, modulus and nbits; set base=msg, acc=1, count=0.
REQ-020 From IDLE + start, the next state SHALL be CHECK if nbits!=0, else FIN.
REQ-021 CHECK: if exponent[count]=1 go to MUL, else go to SQR; CHECK lasts one cycle.
REQ-022 MUL: mul_req=1, mul_a=acc, mul_b=base; on mul_req&&mul_ack set acc=mul_p.
REQ-023 On leaving MUL: if count==nbits-1 go to FIN, else go to SQR.
REQ-024 SQR: mul_req=1, mul_a=base, mul_b=base; on mul_ack set base=mul_p, count=count+1, then go to CHECK.
REQ-025 The final squaring SHALL be skipped: SQR is never entered when count==nbits-1.
REQ-026 When count==nbits-1 and the bit is 0, CHECK SHALL go directly to FIN.
REQ-027 FIN: result=acc, done=1 for one cycle, then return to IDLE.
REQ-028 mul_req, mul_a, mul_b and mul_n SHALL be registered and held stable while mul_req=1 and mul_ack=0.
REQ-029 mul_req SHALL drop in the cycle after the acknowledge; no back-to-back request is issued without an intervening CHECK or state change.
REQ-030 mul_ack SHALL be ignored when mul_req=0.
REQ-031 start SHALL be ignored while busy.
REQ-032 A start in the FIN cycle SHALL be ignored.
REQ-033 Multiplier latency SHALL be unbounded; there is no timeout.
REQ-034 count SHALL never exceed nbits-1 and SHALL never wrap.

Reset
REQ-035 On reset: state=IDLE, mul_req=0, busy=0, done=0, count=0, result=0, acc=1, base=0.
REQ-036 Reset mid-operation SHALL abort immediately, with mul_req low in the next cycle.
REQ-037 A mul_ack arriving after reset SHALL be ignored.

Structure
REQ-038 The state encoding and the DW and WIDTH defaults SHALL live in the shared package rsa_pkg.
REQ-039 The module SHALL be a single FSM with no sub-module instantiated.
REQ-040 The modular multiplier SHALL be external (modmul) and connected via the req/ack handshake.

Verification
REQ-041 msg=4, exponent=13, modulus=497, nbits=4, responder ack latency 1 -> exactly 6 handshakes (3 MUL, 3 SQR), done pulse, result=445.
REQ-042 msg=2, exponent=10, modulus=1000, nbits=4, random ack latency 1-8 -> result=24, operands stable throughout each wait.
REQ-043 nbits=0 -> no mul_req, done 2 cycles after start, result=1.
REQ-044 start pulsed while busy with different operands -> ignored; first result unchanged (445).
REQ-045 reset asserted during a MUL wait, then the late ack delivered -> mul_req=0, state IDLE, no done; a fresh start then completes correctly.
REQ-046 exponent=0xFFFF, nbits=20 -> processing clamped to 16 bits; count peaks at 15; 16 MUL and 15 SQR handshakes.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation datapath: default widths and
// the sequencer state encoding.
package rsa_pkg;

  localparam int RSA_DW    = 16;
  localparam int RSA_WIDTH = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_MUL   = 3'd2,
    ST_SQR   = 3'd3,
    ST_FIN   = 3'd4
  } exp_state_t;

endpackage

// File: rtl/exp_sequencer.sv
// Right-to-left square-and-multiply sequencer driving an external modular
// multiplier through a registered req/ack handshake.
module exp_sequencer
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int DW    = RSA_DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DW-1:0]    msg,
  input  logic [DW-1:0]    exponent,
  input  logic [DW-1:0]    modulus,
  input  logic [WIDTH-1:0] nbits,
  output logic             mul_req,
  output logic [DW-1:0]    mul_a,
  output logic [DW-1:0]    mul_b,
  output logic [DW-1:0]    mul_n,
  input  logic             mul_ack,
  input  logic [DW-1:0]    mul_p,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [DW-1:0]    result
);

  exp_state_t       state_r, state_next_s;
  logic [DW-1:0]    base_r, acc_r, exponent_r, exp_shift_s;
  logic [DW-1:0]    mul_a_r, mul_b_r, mul_n_r, result_r;
  logic [WIDTH-1:0] nbits_r, nbits_clamp_s, count_r;
  logic             mul_req_r, busy_r, done_r;
  logic             ack_s, bit_s, last_s;

  assign nbits_clamp_s = (nbits > WIDTH'(DW)) ? WIDTH'(DW) : nbits;
  assign exp_shift_s   = exponent_r >> count_r;
  assign bit_s         = exp_shift_s[0];
  assign last_s        = (count_r == (nbits_r - WIDTH'(1)));
  // An acknowledge only counts against an outstanding request.
  assign ack_s         = mul_req_r & mul_ack;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; the last bit never gets a trailing squaring.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = (nbits_clamp_s != WIDTH'(0)) ? ST_CHECK : ST_FIN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (bit_s) begin
          state_next_s = ST_MUL;
        end else if (last_s) begin
          state_next_s = ST_FIN;
        end else begin
          state_next_s = ST_SQR;
        end
      end
      ST_MUL: begin
        if (ack_s) begin
          state_next_s = last_s ? ST_FIN : ST_SQR;
        end else begin
          state_next_s = ST_MUL;
        end
      end
      ST_SQR: begin
        if (ack_s) begin
          state_next_s = ST_CHECK;
        end else begin
          state_next_s = ST_SQR;
        end
      end
      ST_FIN:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Datapath and registered handshake; a request is raised one cycle after
  // entering MUL/SQR and dropped on the edge that consumes the ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_r     <= DW'(0);
      acc_r      <= DW'(1);
      exponent_r <= DW'(0);
      nbits_r    <= WIDTH'(0);
      count_r    <= WIDTH'(0);
      mul_req_r  <= 1'b0;
      mul_a_r    <= DW'(0);
      mul_b_r    <= DW'(0);
      mul_n_r    <= DW'(0);
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= DW'(0);
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            base_r     <= msg;
            acc_r      <= DW'(1);
            exponent_r <= exponent;
            nbits_r    <= nbits_clamp_s;
            mul_n_r    <= modulus;
            count_r    <= WIDTH'(0);
            busy_r     <= 1'b1;
          end
        end
        ST_MUL: begin
          if (ack_s) begin
            acc_r     <= mul_p;
            mul_req_r <= 1'b0;
          end else if (!mul_req_r) begin
            mul_req_r <= 1'b1;
            mul_a_r   <= acc_r;
            mul_b_r   <= base_r;
          end
        end
        ST_SQR: begin
          if (ack_s) begin
            base_r    <= mul_p;
            count_r   <= count_r + WIDTH'(1);
            mul_req_r <= 1'b0;
          end else if (!mul_req_r) begin
            mul_req_r <= 1'b1;
            mul_a_r   <= base_r;
            mul_b_r   <= base_r;
          end
        end
        ST_FIN: begin
          result_r <= acc_r;
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
        end
        default: begin
          mul_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign mul_req = mul_req_r;
  assign mul_a   = mul_a_r;
  assign mul_b   = mul_b_r;
  assign mul_n   = mul_n_r;
  assign count   = count_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign result  = result_r;

endmodule

// File: tb/tb_exp_sequencer.sv
// Self-checking bench for exp_sequencer: modular-multiplier responder with
// random latency, checked against a plain-arithmetic exponentiation model.
module tb_exp_sequencer;

  localparam int WIDTH = 6;
  localparam int DW    = 16;

  logic             clk = 1'b0;
  logic             reset, start;
  logic [DW-1:0]    msg, exponent, modulus;
  logic [WIDTH-1:0] nbits;
  logic             mul_req, mul_ack;
  logic [DW-1:0]    mul_a, mul_b, mul_n, mul_p;
  logic [WIDTH-1:0] count;
  logic             busy, done;
  logic [DW-1:0]    result;

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;
  op_t exp_q[$];

  always #5 clk = ~clk;

  exp_sequencer #(.WIDTH(WIDTH), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .msg(msg), .exponent(exponent),
    .modulus(modulus), .nbits(nbits), .mul_req(mul_req), .mul_a(mul_a),
    .mul_b(mul_b), .mul_n(mul_n), .mul_ack(mul_ack), .mul_p(mul_p),
    .count(count), .busy(busy), .done(done), .result(result)
  );

  // Reference: right-to-left binary exponentiation, recording every multiply.
  task automatic build_model(input logic [DW-1:0] m_msg, input logic [DW-1:0] e,
                             input logic [DW-1:0] m, input int n_in,
                             output logic [DW-1:0] res, output int nops);
    longint r, b;
    int n;
    logic [DW-1:0] sh;
    r = 1; b = longint'(m_msg);
    n = (n_in > DW) ? DW : n_in;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      sh = e >> i;
      if (sh[0]) begin
        exp_q.push_back('{a: DW'(r), b: DW'(b)});
        r = (r * b) % longint'(m);
      end
      if (i < n - 1) begin
        exp_q.push_back('{a: DW'(b), b: DW'(b)});
        b = (b * b) % longint'(m);
      end
    end
    nops = exp_q.size();
    res = DW'(r);
  endtask

  task automatic run_op(input logic [DW-1:0] m_msg, input logic [DW-1:0] e,
                        input logic [DW-1:0] m, input logic [WIDTH-1:0] n,
                        input int maxlat, input int start_len, input bit inject,
                        output logic [DW-1:0] res_o, output int done_cyc,
                        output int hs, output int peak);
    bit waiting;
    int wc, lat;
    op_t snap;
    waiting = 1'b0; wc = 0; lat = 1; hs = 0; peak = 0; done_cyc = -1;
    snap = '0;
    @(negedge clk);
    msg = m_msg; exponent = e; modulus = m; nbits = n; start = 1'b1;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc >= start_len) start = 1'b0;
      if (inject && cyc == 5) begin
        start = 1'b1; msg = 16'd7; exponent = 16'd3; modulus = 16'd11; nbits = 6'd2;
      end
      if (mul_ack) begin
        mul_ack = 1'b0;
        vectors++;
        if (mul_req !== 1'b0) begin
          errors++; $display("FAIL req_drop: mul_req=%b required 0", mul_req);
        end
      end
      if (done === 1'b1) begin done_cyc = cyc; break; end
      if (busy && int'(count) > peak) peak = int'(count);
      if (mul_req === 1'b1) begin
        vectors++;
        if (!waiting) begin
          waiting = 1'b1; wc = 0;
          lat = int'($urandom_range(1, maxlat));
          snap = '{a: mul_a, b: mul_b};
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL extra_req: a=%0d b=%0d with no multiply expected", mul_a, mul_b);
          end else if (snap !== exp_q[0] || mul_n !== m) begin
            errors++;
            $display("FAIL operands: a=%0d b=%0d n=%0d required a=%0d b=%0d n=%0d",
                     mul_a, mul_b, mul_n, exp_q[0].a, exp_q[0].b, m);
          end
        end else if (mul_a !== snap.a || mul_b !== snap.b || mul_n !== m) begin
          errors++;
          $display("FAIL stable: a=%0d b=%0d n=%0d required a=%0d b=%0d n=%0d",
                   mul_a, mul_b, mul_n, snap.a, snap.b, m);
        end
        wc++;
        if (wc >= lat) begin
          mul_ack = 1'b1;
          mul_p = DW'((64'(mul_a) * 64'(mul_b)) % 64'(mul_n));
          waiting = 1'b0;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          hs++;
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (done_cyc < 0) begin
      errors++; $display("FAIL timeout: no done within budget, required done pulse");
    end
    res_o = result;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mul_ack = 1'b0; mul_p = '0;
    msg = '0; exponent = '0; modulus = '0; nbits = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (mul_req !== 1'b0) begin errors++; $display("FAIL rst_req: %b required 0", mul_req); end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_flags: busy=%b done=%b required 0 0", busy, done);
    end
    vectors++;
    if (count !== '0 || result !== '0) begin
      errors++; $display("FAIL rst_vals: count=%0d result=%0d required 0 0", count, result);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] res, exp_res; int dc, hs, pk, nops;
    build_model(16'd4, 16'd13, 16'd497, 4, exp_res, nops);
    run_op(16'd4, 16'd13, 16'd497, 6'd4, 1, 1, 1'b0, res, dc, hs, pk);
    vectors++;
    if (res !== 16'd445) begin errors++; $display("FAIL basic_result: %0d required 445", res); end
    vectors++;
    if (hs !== 6 || nops !== 6) begin errors++; $display("FAIL basic_hs: %0d required 6", hs); end
    vectors++;
    if (pk !== 3) begin errors++; $display("FAIL basic_peak: %0d required 3", pk); end
    repeat (3) @(negedge clk);
    vectors++;
    if (result !== 16'd445 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_hold: result=%0d done=%b busy=%b required 445 0 0", result, done, busy);
    end
  endtask

  task automatic test_random_latency();
    logic [DW-1:0] res, exp_res; int dc, hs, pk, nops;
    build_model(16'd2, 16'd10, 16'd1000, 4, exp_res, nops);
    run_op(16'd2, 16'd10, 16'd1000, 6'd4, 8, 1, 1'b0, res, dc, hs, pk);
    vectors++;
    if (res !== 16'd24) begin errors++; $display("FAIL lat_result: %0d required 24", res); end
    vectors++;
    if (hs !== nops) begin errors++; $display("FAIL lat_hs: %0d required %0d", hs, nops); end
  endtask

  task automatic test_zero_bits();
    logic [DW-1:0] res, exp_res; int dc, hs, pk, nops;
    build_model(16'd9, 16'hFFFF, 16'd13, 0, exp_res, nops);
    run_op(16'd9, 16'hFFFF, 16'd13, 6'd0, 1, 1, 1'b0, res, dc, hs, pk);
    vectors++;
    if (dc !== 2) begin errors++; $display("FAIL zero_latency: done after %0d cycles required 2", dc); end
    vectors++;
    if (hs !== 0 || res !== 16'd1) begin
      errors++; $display("FAIL zero_result: hs=%0d result=%0d required 0 1", hs, res);
    end
  endtask

  task automatic test_busy_start();
    logic [DW-1:0] res, exp_res; int dc, hs, pk, nops;
    build_model(16'd4, 16'd13, 16'd497, 4, exp_res, nops);
    run_op(16'd4, 16'd13, 16'd497, 6'd4, 3, 1, 1'b1, res, dc, hs, pk);
    vectors++;
    if (res !== 16'd445 || hs !== 6) begin
      errors++; $display("FAIL busy_start: result=%0d hs=%0d required 445 6", res, hs);
    end
  endtask

  task automatic test_fin_start();
    logic [DW-1:0] res, exp_res; int dc, hs, pk, nops;
    build_model(16'd3, 16'd5, 16'd7, 0, exp_res, nops);
    run_op(16'd3, 16'd5, 16'd7, 6'd0, 1, 2, 1'b0, res, dc, hs, pk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL fin_start: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_clamp();
    logic [DW-1:0] res, exp_res, m, b; int dc, hs, pk, nops;
    m = DW'($urandom_range(2, 65535));
    b = DW'($urandom_range(0, int'(m) - 1));
    build_model(b, 16'hFFFF, m, 20, exp_res, nops);
    run_op(b, 16'hFFFF, m, 6'd20, 2, 1, 1'b0, res, dc, hs, pk);
    vectors++;
    if (hs !== 31 || nops !== 31) begin errors++; $display("FAIL clamp_hs: %0d required 31", hs); end
    vectors++;
    if (pk !== 15) begin errors++; $display("FAIL clamp_peak: %0d required 15", pk); end
    vectors++;
    if (res !== exp_res) begin errors++; $display("FAIL clamp_result: %0d required %0d", res, exp_res); end
  endtask

  task automatic test_abort();
    logic [DW-1:0] res, exp_res; int dc, hs, pk, nops;
    bit seen, bad;
    @(negedge clk);
    msg = 16'd5; exponent = 16'd1; modulus = 16'd23; nbits = 6'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mul_req === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    vectors++;
    if (!seen) begin errors++; $display("FAIL abort_wait: mul_req=%b required 1", mul_req); end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (mul_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_now: mul_req=%b busy=%b required 0 0", mul_req, busy);
    end
    reset = 1'b0; mul_ack = 1'b1; mul_p = 16'hBEEF;
    @(negedge clk);
    mul_ack = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done !== 1'b0 || mul_req !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (bad) begin errors++; $display("FAIL abort_late_ack: activity after aborted op, required idle"); end
    build_model(16'd5, 16'd6, 16'd23, 3, exp_res, nops);
    run_op(16'd5, 16'd6, 16'd23, 6'd3, 4, 1, 1'b0, res, dc, hs, pk);
    vectors++;
    if (res !== exp_res || hs !== nops) begin
      errors++; $display("FAIL abort_restart: result=%0d hs=%0d required %0d %0d", res, hs, exp_res, nops);
    end
  endtask

  task automatic test_random_ops();
    logic [DW-1:0] res, exp_res, m, b, e; logic [WIDTH-1:0] n; int dc, hs, pk, nops;
    for (int t = 0; t < 20; t++) begin
      m = DW'($urandom_range(2, 65535));
      b = DW'($urandom_range(0, int'(m) - 1));
      e = DW'($urandom);
      n = WIDTH'($urandom_range(0, 20));
      build_model(b, e, m, int'(n), exp_res, nops);
      run_op(b, e, m, n, int'($urandom_range(1, 4)), 1, 1'b0, res, dc, hs, pk);
      vectors++;
      if (res !== exp_res || hs !== nops) begin
        errors++;
        $display("FAIL rand_op: msg=%0d e=%h m=%0d n=%0d result=%0d hs=%0d required %0d %0d",
                 b, e, m, n, res, hs, exp_res, nops);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_latency();
    test_zero_bits();
    test_busy_start();
    test_fin_start();
    test_clamp();
    test_abort();
    test_random_ops();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
